// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module  : uart_cmd_parser
// Purpose : Framed command decoder (header, command, count, checksum) with
//           an inter-byte timeout; publishes the accepted sample count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter logic [7:0]  CMD_SET     = 8'h01,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic [7:0] receive_time,
    output logic       set_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    // Expiry is decided one cycle early so frame_err lands exactly
    // TIMEOUT_CYC cycles after the last consumed byte.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 2);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_CNT  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    receive_time_q, receive_time_d;
    logic          set_done_q, set_done_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tmo_q          <= '0;
            cmd_q          <= 8'd0;
            cnt_q          <= 8'd0;
            receive_time_q <= 8'd0;
            set_done_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            cmd_q          <= cmd_d;
            cnt_q          <= cnt_d;
            receive_time_q <= receive_time_d;
            set_done_q     <= set_done_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = '0;
        cmd_d          = cmd_q;
        cnt_d          = cnt_q;
        receive_time_d = receive_time_q;
        set_done_d     = 1'b0;
        frame_err_d    = 1'b0;

        if (state_q != S_IDLE && !data_valid) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end

        if (data_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (data == HEADER) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_d   = data;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    cnt_d   = data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (data == (HEADER ^ cmd_q ^ cnt_q) && cmd_q == CMD_SET && cnt_q != 8'd0) begin
                        receive_time_d = cnt_q;
                        set_done_d     = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign receive_time = receive_time_q;
    assign set_done     = set_done_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module  : tb_uart_cmd_parser
// Purpose : Directed plus randomized bench for uart_cmd_parser against a
//           byte-queue frame model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

    localparam logic [7:0] HDR  = 8'hAA;
    localparam logic [7:0] CSET = 8'h01;
    localparam int         TMO  = 100;

    logic       clk;
    logic       rst_n;
    logic       data_valid;
    logic [7:0] data;
    logic [7:0] receive_time;
    logic       set_done;
    logic       frame_err;
    logic       busy;

    uart_cmd_parser #(
        .HEADER      (HDR),
        .CMD_SET     (CSET),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_valid   (data_valid),
        .data         (data),
        .receive_time (receive_time),
        .set_done     (set_done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: bytes of the frame collected so far, plus cycle of the last byte.
    logic [7:0] m_q[$];
    int         m_cyc  = 0;
    int         m_last = 0;
    logic [7:0] e_rt   = 8'd0;
    logic       e_done = 1'b0;
    logic       e_err  = 1'b0;
    logic       e_busy = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("set_done",     {7'd0, set_done},  {7'd0, e_done});
        check("frame_err",    {7'd0, frame_err}, {7'd0, e_err});
        check("busy",         {7'd0, busy},      {7'd0, e_busy});
        check("receive_time", receive_time,      e_rt);
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d);
        e_done = 1'b0;
        e_err  = 1'b0;
        if (m_q.size() > 0) begin
            if (dv) begin
                m_q.push_back(d);
                m_last = m_cyc;
                if (m_q.size() == 4) begin
                    if (m_q[3] == (m_q[0] ^ m_q[1] ^ m_q[2]) && m_q[1] == CSET && m_q[2] != 8'd0) begin
                        e_rt   = m_q[2];
                        e_done = 1'b1;
                    end else begin
                        e_err = 1'b1;
                    end
                    m_q.delete();
                end
            end else if (m_cyc - m_last == TMO - 1) begin
                e_err = 1'b1;
                m_q.delete();
            end
        end else if (dv && d == HDR) begin
            m_q.push_back(d);
            m_last = m_cyc;
        end
        e_busy = (m_q.size() > 0);
        m_cyc++;
    endtask

    task automatic step(input logic dv, input logic [7:0] d);
        data_valid = dv;
        data       = dv ? d : 8'($urandom_range(0, 255));
        model_step(dv, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] n, input logic [7:0] k);
        send(HDR); send(c); send(n); send(k);
    endtask

    task automatic do_reset(input int n);
        data_valid = 1'b0;
        rst_n      = 1'b0;
        m_q.delete();
        e_rt   = 8'd0;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_busy = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            m_cyc++;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic rand_gap();
        if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(TMO - 5, TMO + 5)));
        else idle(int'($urandom_range(0, 3)));
    endtask

    initial begin
        logic [7:0] c, n, k;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        @(posedge clk);
        #1;
        do_reset(3);

        // Valid frame and three rejects that must leave receive_time alone.
        send_frame(8'h01, 8'h0A, 8'hA1); idle(2);
        check("rt_after_valid", receive_time, 8'h0A);
        send_frame(8'h01, 8'h0A, 8'h00); idle(2);
        send_frame(8'h02, 8'h05, 8'hAD); idle(2);
        send_frame(8'h01, 8'h00, 8'hAB); idle(2);
        check("rt_after_rejects", receive_time, 8'h0A);

        // Leading garbage, then back-to-back frame.
        send(8'h13); send(8'h55); send_frame(8'h01, 8'h20, 8'h8B); idle(2);

        // Timeout, then recovery.
        send(HDR); send(8'h01); idle(150);
        send_frame(8'h01, 8'h0A, 8'hA1); idle(2);

        // Byte arriving exactly on the expiry cycle wins.
        send(HDR); idle(TMO - 2); send(8'h01); send(8'h0A); send(8'hA1); idle(2);
        check("rt_after_collision", receive_time, 8'h0A);

        // Reset mid-frame.
        send(HDR); send(8'h01);
        do_reset(3);
        idle(1);
        send_frame(8'h01, 8'h05, 8'hAE); idle(2);
        check("rt_after_reset_frame", receive_time, 8'h05);

        // Randomized frames with occasional corruption and stalls.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    for (int j = 0; j < 3; j++) send(8'($urandom_range(0, 255)));
                end
                1: begin
                    c = 8'($urandom_range(0, 255));
                    n = 8'($urandom_range(0, 255));
                    k = 8'($urandom_range(0, 255));
                    send_frame(c, n, k);
                end
                default: begin
                    c = ($urandom_range(0, 7) == 0) ? 8'h02 : CSET;
                    n = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                    k = HDR ^ c ^ n;
                    if ($urandom_range(0, 9) == 0) k = k ^ 8'h10;
                    send(HDR); rand_gap(); send(c); rand_gap(); send(n); rand_gap(); send(k);
                end
            endcase
            idle(int'($urandom_range(0, 2)));
        end
        idle(TMO + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Framed command decoder between uart_rx and fifo_wr_ctrl. It consumes received bytes (data/data_valid), validates a 4-byte frame (header, command, count, checksum) with an inter-byte timeout, and publishes the requested sample count as receive_time with a one-cycle set_done strobe. Malformed or stalled frames are dropped and flagged on frame_err; receive_time is never corrupted by a bad frame.

Parameters:
HEADER, 8'hAA, frame start byte
CMD_SET, 8'h01, only accepted command code (set capture count)
TIMEOUT_CYC, 200000, max clk cycles between bytes of one frame (about 3.8 byte times at 50 MHz / 9600 baud); must be >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
data_valid  input  1  one-cycle strobe from uart_rx; byte on data is valid this cycle
data  input  8  received byte
receive_time  output  8  last accepted sample count, held until the next accepted frame
set_done  output  1  one-cycle pulse: receive_time has just been updated
frame_err  output  1  one-cycle pulse: frame rejected (checksum, command, zero count, timeout)
busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, receive_time=8'd0, set_done=0, frame_err=0, busy=0, timeout counter=0, captured cmd/cnt=0.
- FSM states: IDLE, CMD, CNT, CHK. Bytes are consumed only in cycles with data_valid=1; back-to-back data_valid on consecutive cycles must each be consumed.
- IDLE: data_valid and data==HEADER -> CMD. Any other byte is discarded silently (no frame_err) and the FSM stays in IDLE.
- CMD: data_valid -> capture cmd, go to CNT.
- CNT: data_valid -> capture cnt, go to CHK.
- CHK: data_valid -> go to IDLE. The frame is accepted when data == HEADER^cmd^cnt, cmd==CMD_SET and cnt!=0. Otherwise it is rejected.
- Accept: on the next clock edge, receive_time<=cnt and set_done=1 for exactly one cycle. Latency is 1 cycle after the checksum byte's data_valid.
- Reject: frame_err=1 for one cycle with the same 1-cycle latency. receive_time is unchanged and set_done stays 0.
- A HEADER value received in CMD/CNT/CHK is treated as ordinary data. There is no mid-frame resync.
- Timeout counter:
  - Cleared on every data_valid.
  - Cleared and held at 0 while in IDLE.
  - Increments every cycle in CMD/CNT/CHK.
  - When it reaches TIMEOUT_CYC-1 with data_valid=0, the FSM goes to IDLE and frame_err pulses next cycle. frame_err is therefore high TIMEOUT_CYC cycles after the last consumed byte's data_valid cycle.
  - If data_valid coincides with expiry, data_valid wins: the byte is processed normally and the counter is cleared.
- busy is registered and equals (state != IDLE).
- set_done and frame_err are never high in the same cycle.
- Reset mid-frame: the partial frame is discarded, receive_time returns to 0, and no pulse is generated.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Valid frame: bytes AA,01,0A,A1 -> set_done high exactly 1 cycle, 1 cycle after the A1 strobe; receive_time=0x0A; frame_err never high; busy falls with set_done.
- Bad checksum / bad command / zero count: AA,01,0A,00 -> frame_err 1 cycle, receive_time stays 0x0A. AA,02,05,AD -> frame_err. AA,01,00,AB -> frame_err. No set_done in any case.
- Leading garbage and back-to-back: bytes 13,55,AA,01,20,8B on consecutive data_valid cycles -> no frame_err; set_done once; receive_time=0x20.
- Timeout (TIMEOUT_CYC=100): AA,01, then 150 idle cycles -> frame_err exactly 100 cycles after the 01 strobe; busy then 0. A following AA,01,0A,A1 is accepted normally.
- Expiry collision (TIMEOUT_CYC=100): after AA, the next byte 01 arrives on the expiry cycle -> no frame_err; the frame continues and AA,01,0A,A1 is accepted.
- Reset mid-frame: AA,01, assert rst_n=0 for 3 cycles, release -> receive_time=0, busy=0, no pulses. A subsequent valid frame AA,01,05,AE -> receive_time=0x05.
